// File: rtl/spatz_controller.sv
// Issue scheduler between the Spatz decoder and the VFU/VLSU/VSLDU: scoreboards
// pending vreg writes, holds one instruction per unit and tags each dispatch.
module spatz_controller #(
    parameter int unsigned NrVregs = 32,
    parameter int unsigned NrUnits = 3,
    parameter int unsigned IdWidth = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [1:0]                   req_unit_i,
    input  logic [4:0]                   req_vd_i,
    input  logic [4:0]                   req_vs1_i,
    input  logic [4:0]                   req_vs2_i,
    input  logic                         req_use_vd_i,
    input  logic                         req_use_vs1_i,
    input  logic                         req_use_vs2_i,
    output logic [NrUnits-1:0]           issue_valid_o,
    input  logic [NrUnits-1:0]           issue_ready_i,
    output logic [NrUnits*IdWidth-1:0]   issue_id_o,
    input  logic [NrUnits-1:0]           done_i,
    output logic [NrVregs-1:0]           vreg_busy_o,
    output logic                         busy_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2} state_e;

    state_e               state_q [NrUnits];
    state_e               state_d [NrUnits];
    logic [IdWidth-1:0]   tag_q   [NrUnits];
    logic [IdWidth-1:0]   tag_d   [NrUnits];
    logic [4:0]           vd_q    [NrUnits];
    logic [4:0]           vd_d    [NrUnits];
    logic [NrUnits-1:0]   wr_q, wr_d;
    logic [NrUnits-1:0]   issue_valid_q, issue_valid_d;
    logic [NrUnits-1:0]   sel;
    logic [NrVregs-1:0]   sb_q, sb_d;
    logic [IdWidth-1:0]   cnt_q, cnt_d;
    logic                 unit_idle, hazard, accept;

    // An out-of-range unit index selects nothing, so unit_idle stays 0.
    always_comb begin
        sel       = '0;
        unit_idle = 1'b0;
        for (int unsigned u = 0; u < NrUnits; u++) begin
            if (32'(req_unit_i) == u) begin
                sel[u]    = 1'b1;
                unit_idle = (state_q[u] == IDLE);
            end
        end
        hazard = (req_use_vs1_i && sb_q[req_vs1_i]) ||
                 (req_use_vs2_i && sb_q[req_vs2_i]) ||
                 (req_use_vd_i  && sb_q[req_vd_i]);
        req_ready_o = !rst_i && unit_idle && !hazard;
        accept      = req_valid_i && req_ready_o;
    end

    always_comb begin
        cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
        sb_d  = sb_q;
        wr_d  = wr_q;
        for (int unsigned u = 0; u < NrUnits; u++) begin
            state_d[u] = state_q[u];
            tag_d[u]   = tag_q[u];
            vd_d[u]    = vd_q[u];
            case (state_q[u])
                IDLE: if (accept && sel[u]) begin
                    state_d[u] = ISSUE;
                    tag_d[u]   = cnt_q;
                    vd_d[u]    = req_vd_i;
                    wr_d[u]    = req_use_vd_i;
                end
                ISSUE: if (issue_ready_i[u]) state_d[u] = BUSY;
                BUSY: if (done_i[u]) begin
                    state_d[u] = IDLE;
                    if (wr_q[u]) sb_d[vd_q[u]] = 1'b0;
                end
                default: state_d[u] = IDLE;
            endcase
            issue_valid_d[u] = (state_d[u] == ISSUE);
        end
        // WAW stall guarantees this set never collides with a clear above.
        if (accept && req_use_vd_i) sb_d[req_vd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            sb_q          <= '0;
            wr_q          <= '0;
            issue_valid_q <= '0;
            for (int unsigned u = 0; u < NrUnits; u++) begin
                state_q[u] <= IDLE;
                tag_q[u]   <= '0;
                vd_q[u]    <= '0;
            end
        end else begin
            cnt_q         <= cnt_d;
            sb_q          <= sb_d;
            wr_q          <= wr_d;
            issue_valid_q <= issue_valid_d;
            for (int unsigned u = 0; u < NrUnits; u++) begin
                state_q[u] <= state_d[u];
                tag_q[u]   <= tag_d[u];
                vd_q[u]    <= vd_d[u];
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int unsigned u = 0; u < NrUnits; u++) busy_o = busy_o | (state_q[u] != IDLE);
    end

    for (genvar g = 0; g < NrUnits; g++) begin : g_id
        assign issue_id_o[g*IdWidth +: IdWidth] = tag_q[g];
    end

    assign issue_valid_o = issue_valid_q;
    assign vreg_busy_o   = sb_q;

endmodule

// File: tb/tb_spatz_controller.sv
// Bench for spatz_controller: expected tags queued per unit at accept time and
// checked when the unit handshakes its dispatch.
module tb_spatz_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_unit;
    logic [4:0]  req_vd, req_vs1, req_vs2;
    logic        use_vd, use_vs1, use_vs2;
    logic [2:0]  issue_valid, issue_ready, done;
    logic [8:0]  issue_id;
    logic [31:0] vreg_busy;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [2:0] tag_m;
    logic [2:0] q0[$], q1[$], q2[$];

    spatz_controller dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_unit_i(req_unit),
        .req_vd_i(req_vd), .req_vs1_i(req_vs1), .req_vs2_i(req_vs2),
        .req_use_vd_i(use_vd), .req_use_vs1_i(use_vs1), .req_use_vs2_i(use_vs2),
        .issue_valid_o(issue_valid), .issue_ready_i(issue_ready), .issue_id_o(issue_id),
        .done_i(done), .vreg_busy_o(vreg_busy), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int u);
        case (u)
            0: q0.push_back(tag_m);
            1: q1.push_back(tag_m);
            default: q2.push_back(tag_m);
        endcase
        tag_m = tag_m + 3'd1;
    endtask

    task automatic pop_chk(input int u, input logic [2:0] got);
        logic [2:0] e;
        int sz;
        sz = (u == 0) ? q0.size() : (u == 1) ? q1.size() : q2.size();
        chk("iss_expected", sz > 0, 1);
        if (sz > 0) begin
            case (u)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("iss_tag_u%0d", u), got, e);
        end
    endtask

    // Dispatch handshake monitor, sampled away from the rising edge.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++)
            if (!rst && issue_valid[u] && issue_ready[u]) pop_chk(u, issue_id[u*3 +: 3]);
    end

    task automatic drive(input logic [1:0] u, input logic [4:0] vd, input logic [4:0] vs2,
                         input logic uvd, input logic uvs2);
        req_valid = 1'b1; req_unit = u; req_vd = vd; req_vs1 = 5'd0; req_vs2 = vs2;
        use_vd = uvd; use_vs1 = 1'b0; use_vs2 = uvs2;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; use_vd = 1'b0; use_vs1 = 1'b0; use_vs2 = 1'b0;
    endtask

    task automatic pulse_done(input logic [2:0] m);
        done = m;
        tick();
        done = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        tag_m = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_req();
        req_unit = 2'd0; req_vd = 5'd0; req_vs1 = 5'd0; req_vs2 = 5'd0;
        issue_ready = 3'b111; done = 3'b000;
        do_reset();
        chk("rst_valid", issue_valid, 0);
        chk("rst_sb", vreg_busy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", issue_id, 0);

        // Single dispatch to unit 0, vd=3
        drive(2'd0, 5'd3, 5'd0, 1'b1, 1'b0); #1;
        chk("t1_ready", req_ready, 1);
        push_exp(0);
        tick(); idle_req(); #1;
        chk("t1_valid", issue_valid, 3'b001);
        chk("t1_sb", vreg_busy, 32'h8);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_vdrop", issue_valid, 0);

        // RAW on v3 until the cycle after done
        drive(2'd1, 5'd0, 5'd3, 1'b0, 1'b1); #1;
        chk("t2_raw", req_ready, 0);
        tick();
        chk("t2_raw2", req_ready, 0);
        done = 3'b001; #1;
        chk("t2_nobypass", req_ready, 0);
        tick(); done = 3'b000; #1;
        chk("t2_freed", req_ready, 1);
        chk("t2_sb", vreg_busy, 0);
        push_exp(1);
        tick(); idle_req(); #1;
        chk("t2_valid", issue_valid, 3'b010);
        tick();
        pulse_done(3'b010); #1;
        chk("t2_idle", busy, 0);

        // Unit 2 back-pressured for 4 cycles
        issue_ready = 3'b011;
        drive(2'd2, 5'd5, 5'd0, 1'b1, 1'b0); #1;
        chk("t3_ready", req_ready, 1);
        push_exp(2);
        tick();
        drive(2'd2, 5'd6, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_hold", issue_valid[2], 1);
            chk("t3_tag", issue_id[8:6], 3'd2);
            chk("t3_2nd", req_ready, 0);
            tick();
        end
        idle_req();
        issue_ready = 3'b111;
        tick(); #1;
        chk("t3_busy_st", issue_valid, 0);
        chk("t3_sb", vreg_busy, 32'h20);
        chk("t3_busy", busy, 1);
        pulse_done(3'b100); #1;
        chk("t3_sbclr", vreg_busy, 0);
        chk("t3_idle", busy, 0);

        // Independent requests to all three units, simultaneous completion
        drive(2'd0, 5'd1, 5'd0, 1'b1, 1'b0); #1;
        chk("t4_r0", req_ready, 1); push_exp(0); tick();
        drive(2'd1, 5'd2, 5'd0, 1'b1, 1'b0); #1;
        chk("t4_r1", req_ready, 1); push_exp(1); tick();
        drive(2'd2, 5'd4, 5'd0, 1'b1, 1'b0); #1;
        chk("t4_r2", req_ready, 1); push_exp(2); tick();
        idle_req(); #1;
        chk("t4_sb", vreg_busy, 32'h16);
        chk("t4_busy", busy, 1);
        tick();
        drive(2'd3, 5'd9, 5'd0, 1'b0, 1'b0); #1;
        chk("t4_badunit", req_ready, 0);
        idle_req();
        pulse_done(3'b111); #1;
        chk("t4_sbclr", vreg_busy, 0);
        chk("t4_idle", busy, 0);

        // Tag wrap: fresh counter, 9 dispatches on unit 0
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(2'd0, 5'd8, 5'd0, 1'b1, 1'b0); #1;
            chk("t5_ready", req_ready, 1);
            push_exp(0);
            tick(); idle_req();
            tick();
            pulse_done(3'b001);
        end
        #1;
        chk("t5_idle", busy, 0);

        // Asynchronous reset while busy
        drive(2'd1, 5'd7, 5'd0, 1'b1, 1'b0); #1;
        chk("t6_ready", req_ready, 1);
        push_exp(1);
        tick(); idle_req();
        tick(); #1;
        chk("t6_sb", vreg_busy, 32'h80);
        chk("t6_busy", busy, 1);
        rst = 1'b1; #1;
        chk("t6_rvalid", issue_valid, 0);
        chk("t6_rsb", vreg_busy, 0);
        chk("t6_rbusy", busy, 0);
        do_reset();
        drive(2'd0, 5'd9, 5'd0, 1'b1, 1'b0); #1;
        chk("t6_ready2", req_ready, 1);
        push_exp(0);
        tick(); idle_req();
        tick();
        pulse_done(3'b001);
        tick();

        chk("q_left", q0.size() + q1.size() + q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
